// File: rtl/mips_pkg.sv
// Shared MIPS encodings and the decoded control bundle for the decode stage.
package mips_pkg;

    localparam int unsigned OPC_W     = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALUOP_W   = 2;
    localparam int unsigned ALUCTRL_W = 3;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic                reg_dst;
        logic                branch;
        logic                mem_read;
        logic                mem_to_reg;
        logic                mem_write;
        logic                alu_src;
        logic                reg_write;
        logic [ALUOP_W-1:0]  alu_op;
    } ctrl_t;

    // R-type functs that actually write a result; anything else is a NOP.
    function automatic logic funct_is_known(input logic [FUNCT_W-1:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
               (f == F_OR)  || (f == F_SLT);
    endfunction

endpackage

// File: rtl/alu_control.sv
// ALU select decoder: maps the main decoder's alu_op class and funct to a 3-bit ALU select.
module alu_control
    import mips_pkg::*;
(
    input  logic [ALUOP_W-1:0]   alu_op,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALUCTRL_W-1:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_SLT:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// MIPS main decoder plus ALU control, registered once as the decode-stage output register.
module control_unit
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPC_W-1:0]     opcode,
    input  logic [FUNCT_W-1:0]   funct,
    output logic                 reg_dst,
    output logic                 branch,
    output logic                 mem_read,
    output logic                 mem_to_reg,
    output logic                 mem_write,
    output logic                 alu_src,
    output logic                 reg_write,
    output logic [ALUOP_W-1:0]   alu_op,
    output logic [ALUCTRL_W-1:0] alu_ctrl
);

    ctrl_t                w_ctrl;
    logic [ALUCTRL_W-1:0] w_alu_ctrl;
    ctrl_t                r_ctrl;
    logic [ALUCTRL_W-1:0] r_alu_ctrl;

    // Main decoder; unknown opcodes (including X/Z) fall through to the all-zero NOP.
    always_comb begin
        w_ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                w_ctrl.alu_op = ALUOP_FUNCT;
                if (funct_is_known(funct)) begin
                    w_ctrl.reg_dst   = 1'b1;
                    w_ctrl.reg_write = 1'b1;
                end
            end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            default: w_ctrl = '0;
        endcase
    end

    alu_control u_alu_control (
        .alu_op   (w_ctrl.alu_op),
        .funct    (funct),
        .alu_ctrl (w_alu_ctrl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_alu_ctrl <= '0;
        end else begin
            r_ctrl     <= w_ctrl;
            r_alu_ctrl <= w_alu_ctrl;
        end
    end

    assign reg_dst    = r_ctrl.reg_dst;
    assign branch     = r_ctrl.branch;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign mem_write  = r_ctrl.mem_write;
    assign alu_src    = r_ctrl.alu_src;
    assign reg_write  = r_ctrl.reg_write;
    assign alu_op     = r_ctrl.alu_op;
    assign alu_ctrl   = r_alu_ctrl;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases plus random instructions against a mnemonic-level model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl;

    int n_checks = 0;
    int n_pass   = 0;

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .reg_dst    (reg_dst),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .alu_ctrl   (alu_ctrl)
    );

    always #5 clk = ~clk;

    // Observed vector: {reg_dst,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,alu_op,alu_ctrl}
    function automatic logic [11:0] observed();
        return {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src,
                reg_write, alu_op, alu_ctrl};
    endfunction

    function automatic string mnemonic(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'd32) return "add";
            if (fn == 6'd34) return "sub";
            if (fn == 6'd36) return "and";
            if (fn == 6'd37) return "or";
            if (fn == 6'd42) return "slt";
            return "rnop";
        end
        if (op == 6'd35) return "lw";
        if (op == 6'd43) return "sw";
        if (op == 6'd4)  return "beq";
        if (op == 6'd8)  return "addi";
        return "ill";
    endfunction

    // Expected register contents for an instruction, derived from what it does.
    function automatic logic [11:0] model(input logic [5:0] op, input logic [5:0] fn);
        string m = mnemonic(op, fn);
        logic rd = 0, br = 0, mr = 0, m2r = 0, mw = 0, src = 0, rw = 0;
        logic [1:0] aop = 2'd0;
        logic [2:0] sel = 3'd2;
        if (m == "add" || m == "sub" || m == "and" || m == "or" || m == "slt") begin
            rd = 1; rw = 1; aop = 2'd2;
            if (m == "sub") sel = 3'd6;
            if (m == "and") sel = 3'd0;
            if (m == "or")  sel = 3'd1;
            if (m == "slt") sel = 3'd7;
        end else if (m == "rnop") begin
            aop = 2'd2;
        end else if (m == "lw") begin
            src = 1; m2r = 1; rw = 1; mr = 1;
        end else if (m == "sw") begin
            src = 1; mw = 1;
        end else if (m == "beq") begin
            br = 1; aop = 2'd1; sel = 3'd6;
        end else if (m == "addi") begin
            src = 1; rw = 1;
        end
        return {rd, br, mr, m2r, mw, src, rw, aop, sel};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        opcode = op;
        funct  = fn;
        @(posedge clk);
        #1;
        check(tag, observed(), model(op, fn));
    endtask

    task automatic step_instr(input string tag, input logic [31:0] instr);
        step(tag, instr[31:26], instr[5:0]);
    endtask

    logic [5:0] ops [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8};
    logic [5:0] fns [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};

    initial begin
        rst    = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b100000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", observed(), 12'd0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_release", observed(), {7'b1000001, 2'b10, 3'b010});

        step_instr("lw_instr", 32'h8E32_0014);
        check("lw_abs", observed(), {7'b0011011, 2'b00, 3'b010});
        step_instr("beq_instr", 32'h1149_0022);
        check("beq_abs", observed(), {7'b0100000, 2'b01, 3'b110});

        step("r_sub", 6'd0, 6'b100010);
        step("r_and", 6'd0, 6'b100100);
        step("r_or",  6'd0, 6'b100101);
        step("r_slt", 6'd0, 6'b101010);
        step("r_nop", 6'd0, 6'b000000);
        check("r_nop_abs", observed(), {7'b0000000, 2'b10, 3'b010});
        step("addi",  6'd8, 6'b101010);
        step("sw",    6'd43, 6'b000000);
        step("ill",   6'b111111, 6'b100000);
        check("ill_abs", observed(), {7'b0000000, 2'b00, 3'b010});

        // Asynchronous reset between edges.
        step("lw_pre_rst", 6'd35, 6'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst", observed(), 12'd0);
        @(posedge clk);
        #1;
        check("rst_held_edge", observed(), 12'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_load", observed(), model(6'd35, 6'd0));

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op, fn;
            int unsigned r;
            r  = $urandom_range(0, 9);
            op = (r < 5) ? ops[r] : 6'($urandom);
            r  = $urandom_range(0, 9);
            fn = (r < 5) ? fns[r] : 6'($urandom);
            step("random", op, fn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
